// File: rtl/n101_regvec_wr_arb.sv
// n101_regvec_wr_arb
//
// Write controller for a WIDTH-bit configuration register vector in the n101
// AON domain. Two requesters (bus and hardware) present masked writes. The
// block grants them round-robin and merges each write into the current
// register contents. It strobes the merged value into the register vector,
// waits SETTLE cycles, then reads the vector back and returns one response.
// The register vector itself, with its own asynchronous reset, lives outside
// this block.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   bus_req_*           bus write request (valid/ready/data/mask)
//   hw_req_*            hardware write request (valid/ready/data/mask)
//   lock                refuses bus writes when high at accept
//   rsp_valid           one-cycle response pulse
//   rsp_src             0 = bus, 1 = hw (valid with rsp_valid)
//   rsp_err             refused or read-back mismatch (valid with rsp_valid)
//   reg_d, reg_en       drive the register vector d / en pins
//   reg_q               register vector q outputs
//   busy                high whenever the controller is not idle
module n101_regvec_wr_arb #(
    parameter int WIDTH  = 5,
    parameter int SETTLE = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bus_req_valid,
    output logic             bus_req_ready,
    input  logic [WIDTH-1:0] bus_req_data,
    input  logic [WIDTH-1:0] bus_req_mask,
    input  logic             hw_req_valid,
    output logic             hw_req_ready,
    input  logic [WIDTH-1:0] hw_req_data,
    input  logic [WIDTH-1:0] hw_req_mask,
    input  logic             lock,
    output logic             rsp_valid,
    output logic             rsp_src,
    output logic             rsp_err,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_en,
    input  logic [WIDTH-1:0] reg_q,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WRITE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Last settle-count value. It is only meaningful when SETTLE > 0,
    // because ST_SETTLE is skipped entirely otherwise.
    localparam logic [3:0] SETTLE_LAST = (SETTLE > 0) ? 4'(SETTLE - 1) : 4'd0;

    state_t           state_q, state_d;
    logic             ptr_q;      // 0 = bus favoured, 1 = hw favoured
    logic             src_q;
    logic             locked_q;
    logic [WIDTH-1:0] reg_d_q;
    logic [3:0]       cnt_q;

    logic             idle;
    logic             bus_acc, hw_acc, any_acc, acc_locked, cnt_done;
    logic [WIDTH-1:0] sel_data, sel_mask, merged;

    // Arbitration: a lone requester always wins. On a tie the pointer decides.
    always_comb begin
        idle          = (state_q == ST_IDLE);
        bus_req_ready = idle && bus_req_valid && (!hw_req_valid || !ptr_q);
        hw_req_ready  = idle && hw_req_valid  && (!bus_req_valid || ptr_q);
        bus_acc       = bus_req_valid && bus_req_ready;
        hw_acc        = hw_req_valid  && hw_req_ready;
        any_acc       = bus_acc || hw_acc;
        acc_locked    = bus_acc && lock;
        sel_data      = hw_acc ? hw_req_data : bus_req_data;
        sel_mask      = hw_acc ? hw_req_mask : bus_req_mask;
        merged        = (reg_q & ~sel_mask) | (sel_data & sel_mask);
        cnt_done      = (cnt_q == SETTLE_LAST);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A refused (locked) bus write skips WRITE and goes straight to RESP.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (any_acc) begin
                    state_d = acc_locked ? ST_RESP : ST_WRITE;
                end
            end
            ST_WRITE: begin
                state_d = (SETTLE > 0) ? ST_SETTLE : ST_RESP;
            end
            ST_SETTLE: begin
                if (cnt_done) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture the accepted request. The pointer always moves to the side
    // that was not just served, so tied requesters alternate strictly.
    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q    <= 1'b0;
            src_q    <= 1'b0;
            locked_q <= 1'b0;
            reg_d_q  <= '0;
            cnt_q    <= 4'd0;
        end else begin
            if (any_acc) begin
                src_q    <= hw_acc;
                locked_q <= acc_locked;
                ptr_q    <= bus_acc;
                reg_d_q  <= merged;
            end
            if (state_q == ST_SETTLE) begin
                cnt_q <= cnt_done ? 4'd0 : cnt_q + 4'd1;
            end else begin
                cnt_q <= 4'd0;
            end
        end
    end

    // The read-back compare is done live against reg_q in RESP. An external
    // reset of the vector during settle therefore shows up as an error.
    always_comb begin
        reg_d     = reg_d_q;
        reg_en    = (state_q == ST_WRITE);
        rsp_valid = (state_q == ST_RESP);
        rsp_src   = rsp_valid && src_q;
        rsp_err   = rsp_valid && (locked_q || (reg_q != reg_d_q));
        busy      = (state_q != ST_IDLE);
    end

endmodule

// File: tb/tb_n101_regvec_wr_arb.sv
// tb_n101_regvec_wr_arb
//
// Testbench for n101_regvec_wr_arb. It models the external register vector,
// including its asynchronous clear. Drivers push the expected responses and
// register writes into queues, and a negedge monitor pops and compares them
// against what the DUT presents.
module tb_n101_regvec_wr_arb;

    localparam int WIDTH  = 5;
    localparam int SETTLE = 3;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             bus_req_valid, bus_req_ready;
    logic [WIDTH-1:0] bus_req_data, bus_req_mask;
    logic             hw_req_valid, hw_req_ready;
    logic [WIDTH-1:0] hw_req_data, hw_req_mask;
    logic             lock;
    logic             rsp_valid, rsp_src, rsp_err;
    logic [WIDTH-1:0] reg_d;
    logic             reg_en;
    logic [WIDTH-1:0] reg_q;
    logic             busy;

    logic [WIDTH-1:0] reg_vec;
    logic             ext_clr;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit ptr_model;

    typedef struct {
        bit src;
        bit err;
        int cyc;
    } rsp_t;

    typedef struct {
        logic [WIDTH-1:0] d;
        int               cyc;
    } wr_t;

    rsp_t rsp_q[$];
    wr_t  wr_q[$];
    rsp_t mon_rsp;
    wr_t  mon_wr;

    n101_regvec_wr_arb #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clock         (clock),
        .reset         (reset),
        .bus_req_valid (bus_req_valid),
        .bus_req_ready (bus_req_ready),
        .bus_req_data  (bus_req_data),
        .bus_req_mask  (bus_req_mask),
        .hw_req_valid  (hw_req_valid),
        .hw_req_ready  (hw_req_ready),
        .hw_req_data   (hw_req_data),
        .hw_req_mask   (hw_req_mask),
        .lock          (lock),
        .rsp_valid     (rsp_valid),
        .rsp_src       (rsp_src),
        .rsp_err       (rsp_err),
        .reg_d         (reg_d),
        .reg_en        (reg_en),
        .reg_q         (reg_q),
        .busy          (busy)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // External register vector with its own asynchronous clear.
    always @(posedge clock or posedge ext_clr) begin
        if (ext_clr) reg_vec <= '0;
        else if (reg_en) reg_vec <= reg_d;
    end
    assign reg_q = reg_vec;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: exclusive ready, responses and write strobes against the scoreboard.
    always @(negedge clock) begin
        if (!reset) begin
            check_output("ready_exclusive", 32'(bus_req_ready & hw_req_ready), 32'd0);
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    check_output("unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    mon_rsp = rsp_q.pop_front();
                    check_output("rsp_cycle", 32'(cyc), 32'(mon_rsp.cyc));
                    check_output("rsp_src", 32'(rsp_src), 32'(mon_rsp.src));
                    check_output("rsp_err", 32'(rsp_err), 32'(mon_rsp.err));
                end
            end
            if (reg_en) begin
                if (wr_q.size() == 0) begin
                    check_output("unexpected_reg_en", 32'd1, 32'd0);
                end else begin
                    mon_wr = wr_q.pop_front();
                    check_output("reg_en_cycle", 32'(cyc), 32'(mon_wr.cyc));
                    check_output("reg_d", 32'(reg_d), 32'(mon_wr.d));
                end
            end
        end
    end

    // Single-requester write. mode 0: normal; mode 1: vector cleared during
    // settle; mode 2: response dropped by a reset.
    task automatic apply_stimulus(input bit src, input logic [WIDTH-1:0] data,
                                  input logic [WIDTH-1:0] mask, input bit lk,
                                  input int mode, output int c);
        logic [WIDTH-1:0] merged;
        bit               locked;
        bit               got;
        rsp_t             r;
        wr_t              w;
        c = -1;
        @(negedge clock);
        lock = lk;
        if (src) begin
            hw_req_valid = 1'b1; hw_req_data = data; hw_req_mask = mask;
        end else begin
            bus_req_valid = 1'b1; bus_req_data = data; bus_req_mask = mask;
        end
        got = 1'b0;
        for (int k = 0; k < 64; k++) begin
            #1;
            if ((src ? hw_req_ready : bus_req_ready) === 1'b1) begin
                got = 1'b1;
                break;
            end
            @(negedge clock);
        end
        if (!got) begin
            check_output("grant_timeout", 32'd0, 32'd1);
            bus_req_valid = 1'b0;
            hw_req_valid  = 1'b0;
            return;
        end
        c      = cyc;
        merged = (reg_vec & ~mask) | (data & mask);
        locked = !src && lk;
        r.src  = src;
        r.err  = locked ? 1'b1 : ((mode == 1) ? (merged != '0) : 1'b0);
        r.cyc  = locked ? c + 1 : c + 2 + SETTLE;
        if (mode != 2) rsp_q.push_back(r);
        if (!locked) begin
            w.d   = merged;
            w.cyc = c + 1;
            wr_q.push_back(w);
        end
        ptr_model = ~src;
        @(posedge clock);
        #1;
        bus_req_valid = 1'b0;
        hw_req_valid  = 1'b0;
        lock          = 1'($urandom_range(0, 1));
    endtask

    // Both requesters held valid for n operations; grants must alternate.
    task automatic apply_both(input int n);
        logic [WIDTH-1:0] merged;
        bit               got, exp_src;
        rsp_t             r;
        wr_t              w;
        @(negedge clock);
        lock          = 1'b0;
        bus_req_valid = 1'b1;
        bus_req_data  = WIDTH'($urandom);
        bus_req_mask  = WIDTH'($urandom);
        hw_req_valid  = 1'b1;
        hw_req_data   = WIDTH'($urandom);
        hw_req_mask   = WIDTH'($urandom);
        for (int i = 0; i < n; i++) begin
            got = 1'b0;
            for (int k = 0; k < 64; k++) begin
                #1;
                if ((bus_req_ready | hw_req_ready) === 1'b1) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clock);
            end
            if (!got) begin
                check_output("rr_timeout", 32'd0, 32'd1);
                break;
            end
            exp_src = ptr_model;
            check_output("rr_grant_hw", 32'(hw_req_ready), 32'(exp_src));
            check_output("rr_grant_bus", 32'(bus_req_ready), 32'(!exp_src));
            merged = exp_src ? ((reg_vec & ~hw_req_mask) | (hw_req_data & hw_req_mask))
                             : ((reg_vec & ~bus_req_mask) | (bus_req_data & bus_req_mask));
            r.src = exp_src;
            r.err = 1'b0;
            r.cyc = cyc + 2 + SETTLE;
            rsp_q.push_back(r);
            w.d   = merged;
            w.cyc = cyc + 1;
            wr_q.push_back(w);
            ptr_model = ~exp_src;
            @(posedge clock);
            #1;
            if (exp_src) begin
                hw_req_data = WIDTH'($urandom); hw_req_mask = WIDTH'($urandom);
            end else begin
                bus_req_data = WIDTH'($urandom); bus_req_mask = WIDTH'($urandom);
            end
        end
        bus_req_valid = 1'b0;
        hw_req_valid  = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 100; k++) begin
            if (rsp_q.size() == 0 && wr_q.size() == 0) break;
            @(negedge clock);
        end
        check_output("drain", 32'(rsp_q.size() + wr_q.size()), 32'd0);
        @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ptr_model = 1'b0;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int               c;
        logic [WIDTH-1:0] saved;
        bus_req_valid = 0; bus_req_data = '0; bus_req_mask = '0;
        hw_req_valid  = 0; hw_req_data  = '0; hw_req_mask  = '0;
        lock = 0; ext_clr = 0; ptr_model = 0;
        #2 ext_clr = 1;
        #1 ext_clr = 0;
        repeat (3) @(negedge clock);

        // Outputs during reset
        check_output("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("rst_reg_en", 32'(reg_en), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_output("rst_reg_d", 32'(reg_d), 32'd0);
        check_output("rst_ready", 32'({bus_req_ready, hw_req_ready}), 32'd0);
        reset = 1'b0;

        // Full-mask bus write
        apply_stimulus(1'b0, 5'h1F, 5'h1F, 1'b0, 0, c);
        wait_done();
        check_output("reg_q_1f", 32'(reg_vec), 32'h1F);

        // Partial-mask hw write over 0A
        apply_stimulus(1'b0, 5'h0A, 5'h1F, 1'b0, 0, c);
        wait_done();
        apply_stimulus(1'b1, 5'h15, 5'h03, 1'b0, 0, c);
        wait_done();
        check_output("hw_merge", 32'(reg_vec), 32'h09);

        // Round-robin after reset
        do_reset();
        apply_both(4);
        wait_done();

        // Locked bus write refused, hw write unaffected
        saved = reg_vec;
        apply_stimulus(1'b0, 5'h00, 5'h1F, 1'b1, 0, c);
        wait_done();
        check_output("locked_unchanged", 32'(reg_vec), 32'(saved));
        apply_stimulus(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, 0, c);
        wait_done();

        // mask=0 write still strobes
        apply_stimulus(1'b1, 5'h1F, 5'h00, 1'b0, 0, c);
        wait_done();

        // Vector cleared externally during settle
        apply_stimulus(1'b0, 5'h1F, 5'h1F, 1'b0, 1, c);
        while (cyc < c + 2) @(negedge clock);
        ext_clr = 1'b1;
        #1 ext_clr = 1'b0;
        wait_done();

        // Reset during settle
        apply_stimulus(1'b0, 5'h11, 5'h1F, 1'b0, 2, c);
        while (cyc < c + 2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        ptr_model = 1'b0;
        #1;
        check_output("post_rst_busy", 32'(busy), 32'd0);
        check_output("post_rst_rsp", 32'(rsp_valid), 32'd0);
        bus_req_valid = 1'b1;
        hw_req_valid  = 1'b1;
        #1;
        check_output("post_rst_grant", 32'({bus_req_ready, hw_req_ready}), 32'b10);
        bus_req_valid = 1'b0;
        hw_req_valid  = 1'b0;
        apply_both(2);
        wait_done();

        // Randomised single-requester traffic
        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            apply_stimulus(1'($urandom_range(0, 1)), WIDTH'($urandom), WIDTH'($urandom),
                           ($urandom_range(0, 3) == 0), 0, c);
        end
        wait_done();

        check_output("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        check_output("wr_queue_empty", 32'(wr_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
